// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and defaults for the UART transmitter arbiter
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        WAIT_ACK,
        WAIT_DONE
    } arb_state_e;

    localparam int BYTE_W           = 8;
    localparam int CNT_W            = 7;
    localparam int DEF_NREQ         = 4;
    localparam int DEF_LOCK_MAX     = 64;
    localparam int DEF_ACK_TIMEOUT  = 16;
    localparam int DEF_IDLE_TIMEOUT = 256;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority one-hot pick of the first valid request at or above ptr
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic            found
);

    int            j;
    logic [PW-1:0] jj;

    always_comb begin
        onehot = '0;
        found  = 1'b0;
        j      = 0;
        jj     = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            jj = PW'(j);
            if (!found && req[jj]) begin
                onehot[jj] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locking arbiter sharing one UART transmitter
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ         = DEF_NREQ,
    parameter int LOCK_MAX     = DEF_LOCK_MAX,
    parameter int ACK_TIMEOUT  = DEF_ACK_TIMEOUT,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [BYTE_W*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    output logic                   tx_start,
    output logic [BYTE_W-1:0]      tx_data,
    input  logic                   tx_busy,
    output logic [NREQ-1:0]        grant,
    output logic                   locked,
    output logic                   err_timeout,
    input  logic                   err_clr
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    logic [PW-1:0]     ptr_q, owner_q, ptr_after_owner, pick_idx;
    logic [NREQ-1:0]   grant_q, pick_onehot;
    logic              pick_found, locked_q, last_q, err_q;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_inc;
    logic [IW-1:0]     idle_cnt_q;
    logic [AW-1:0]     ack_cnt_q;
    logic [BYTE_W-1:0] tx_data_q;
    logic [BYTE_W-1:0] req_bytes [NREQ];
    logic              owner_valid, idle_expire, ack_expire, release_done;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req    (req_valid),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .found  (pick_found)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_bytes[i] = req_data[i*BYTE_W +: BYTE_W];
            if (pick_onehot[i]) begin
                pick_idx = PW'(i);
            end
        end
    end

    assign owner_valid     = req_valid[owner_q];
    assign ptr_after_owner = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
    assign idle_expire     = locked_q && !owner_valid && (idle_cnt_q >= IW'(IDLE_TIMEOUT - 1));
    assign ack_expire      = !tx_busy && (ack_cnt_q >= AW'(ACK_TIMEOUT - 1));
    assign byte_cnt_inc    = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + CNT_W'(1);
    assign release_done    = last_q || (byte_cnt_inc >= CNT_W'(LOCK_MAX));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // A transmitter still busy (e.g. across a reset) must finish before any new start.
                if (!tx_busy) begin
                    if (locked_q) begin
                        if (owner_valid) state_d = GRANT;
                    end else if (pick_found) begin
                        state_d = GRANT;
                    end
                end
            end
            GRANT:     state_d = START;
            START:     state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (tx_busy)         state_d = WAIT_DONE;
                else if (ack_expire) state_d = IDLE;
            end
            WAIT_DONE: if (!tx_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        tx_start  = 1'b0;
        case (state_q)
            GRANT:   req_ready = grant_q;
            START:   tx_start  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ptr_q      <= '0;
            owner_q    <= '0;
            grant_q    <= '0;
            locked_q   <= 1'b0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
            ack_cnt_q  <= '0;
            tx_data_q  <= '0;
        end else begin
            if (err_clr) err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!tx_busy) begin
                        if (locked_q) begin
                            if (owner_valid) begin
                                idle_cnt_q <= '0;
                            end else if (idle_expire) begin
                                locked_q   <= 1'b0;
                                grant_q    <= '0;
                                byte_cnt_q <= '0;
                                idle_cnt_q <= '0;
                                ptr_q      <= ptr_after_owner;
                            end else begin
                                idle_cnt_q <= idle_cnt_q + IW'(1);
                            end
                        end else if (pick_found) begin
                            grant_q    <= pick_onehot;
                            owner_q    <= pick_idx;
                            idle_cnt_q <= '0;
                        end
                    end
                end
                GRANT: begin
                    tx_data_q <= req_bytes[owner_q];
                    last_q    <= req_last[owner_q];
                end
                START: ack_cnt_q <= '0;
                WAIT_ACK: begin
                    if (!tx_busy) begin
                        // Silent transmitter: drop the byte and let the next requester in.
                        if (ack_expire) begin
                            err_q      <= 1'b1;
                            locked_q   <= 1'b0;
                            grant_q    <= '0;
                            byte_cnt_q <= '0;
                            ptr_q      <= ptr_after_owner;
                        end else begin
                            ack_cnt_q <= ack_cnt_q + AW'(1);
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (release_done) begin
                            locked_q   <= 1'b0;
                            grant_q    <= '0;
                            byte_cnt_q <= '0;
                            ptr_q      <= ptr_after_owner;
                        end else begin
                            locked_q   <= 1'b1;
                            byte_cnt_q <= byte_cnt_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_data     = tx_data_q;
    assign grant       = grant_q;
    assign locked      = locked_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a simple UART transmitter model
module tb_uart_tx_arbiter;

    localparam int NREQ         = 4;
    localparam int ACK_TIMEOUT  = 16;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic [NREQ-1:0]   grant;
    logic              locked;
    logic              err_timeout;
    logic              err_clr;

    uart_tx_arbiter #(.NREQ(NREQ), .LOCK_MAX(64), .ACK_TIMEOUT(ACK_TIMEOUT), .IDLE_TIMEOUT(256)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant       (grant),
        .locked      (locked),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic [7:0] data;
        int         idx;
        logic       lck;
    } exp_t;

    exp_t       expq [$];
    logic [8:0] rq [NREQ][$];
    bit         pend [NREQ];
    int         n_chk = 0, n_fail = 0, cyc = 0;
    int         busy_len = 10;
    bit         ack_en = 1'b1;
    int         rdy_cnt [NREQ];
    int         valid_rise_cyc [NREQ];
    int         last_rdy_cyc = 0, last_rdy_idx = -1, last_start_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic expect_byte(input logic [7:0] d, input int idx, input logic lck);
        exp_t e;
        e.data = d;
        e.idx  = idx;
        e.lck  = lck;
        expq.push_back(e);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (expq.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_drain_left"}, expq.size(), 0);
    endtask

    task automatic wait_tx_done(input string tag);
        int n = 0;
        while (!tx_busy && n < 50) begin step(); n++; end
        chk({tag, "_busy_rise"}, tx_busy, 1);
        n = 0;
        while (tx_busy && n < 100) begin step(); n++; end
        chk({tag, "_busy_fall"}, tx_busy, 0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_tx_start"}, tx_start, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_err"}, err_timeout, 0);
    endtask

    initial forever begin
        @(posedge wb_clk_i);
        cyc++;
    end

    // Transmitter model: busy rises one cycle after a start and holds for busy_len cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            step();
            if (tx_start && ack_en) begin
                step();
                tx_busy = 1'b1;
                repeat (busy_len) @(posedge wb_clk_i);
                #1;
                tx_busy = 1'b0;
            end
        end
    end

    // Requester driver: each requester presents the head of its queue until it sees req_ready.
    initial begin
        logic [8:0] dummy;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i]) begin
                    dummy   = rq[i].pop_front();
                    pend[i] = 1'b0;
                end
                pend[i] = req_ready[i];
                if (rq[i].size() > 0) begin
                    if (!req_valid[i]) valid_rise_cyc[i] = cyc;
                    req_valid[i]       = 1'b1;
                    req_data[i*8 +: 8] = rq[i][0][7:0];
                    req_last[i]        = rq[i][0][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // Monitor: every tx_start is checked against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            step();
            if (req_ready != '0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i]) begin
                        rdy_cnt[i]++;
                        last_rdy_idx = i;
                    end
                end
                last_rdy_cyc = cyc;
            end
            if (tx_start) begin
                last_start_cyc = cyc;
                if (expq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_start: tx_data=%0h with nothing expected", tx_data);
                end else begin
                    e = expq.pop_front();
                    chk("tx_data", tx_data, e.data);
                    chk("owner", last_rdy_idx, e.idx);
                    chk("locked_at_start", locked, e.lck);
                    chk("ready_to_start", cyc - last_rdy_cyc, 1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        wb_rst_i = 1'b1;
        err_clr  = 1'b0;
        repeat (3) step();
        chk_reset_values("reset");
        wb_rst_i = 1'b0;
        step();

        // Single byte from requester 2
        for (int i = 0; i < NREQ; i++) rdy_cnt[i] = 0;
        expect_byte(8'h0F, 2, 1'b0);
        rq[2].push_back({1'b1, 8'h0F});
        wait_drain("single", 200);
        chk("single_valid_to_ready", last_rdy_cyc - valid_rise_cyc[2], 1);
        wait_tx_done("single");
        step();
        chk("single_ready_count", rdy_cnt[2], 1);
        chk("single_other_ready", rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[3], 0);
        chk("single_grant_after", grant, 0);
        chk("single_locked_after", locked, 0);

        // Round robin from a fresh pointer
        wb_rst_i = 1'b1;
        step();
        wb_rst_i = 1'b0;
        rq[0].push_back({1'b1, 8'h10});
        rq[0].push_back({1'b1, 8'h10});
        for (int i = 1; i < NREQ; i++) rq[i].push_back({1'b1, 8'(8'h10 + i)});
        expect_byte(8'h10, 0, 1'b0);
        expect_byte(8'h11, 1, 1'b0);
        expect_byte(8'h12, 2, 1'b0);
        expect_byte(8'h13, 3, 1'b0);
        expect_byte(8'h10, 0, 1'b0);
        wait_drain("rr", 500);
        wait_tx_done("rr");

        // Packet lock: requester 1 keeps the transmitter while requester 0 waits
        rq[1].push_back({1'b0, 8'h3D});
        rq[1].push_back({1'b0, 8'h4F});
        rq[1].push_back({1'b1, 8'h29});
        rq[0].push_back({1'b1, 8'h77});
        expect_byte(8'h3D, 1, 1'b0);
        expect_byte(8'h4F, 1, 1'b1);
        expect_byte(8'h29, 1, 1'b1);
        expect_byte(8'h77, 0, 1'b0);
        wait_drain("lock", 500);
        wait_tx_done("lock");

        // Lock limit: 65-byte packet is cut after byte 64 and requester 0 gets a turn
        busy_len = 2;
        for (int k = 1; k <= 65; k++) begin
            rq[2].push_back({(k == 65), 8'(k)});
            if (k <= 64) expect_byte(8'(k), 2, (k > 1));
        end
        rq[0].push_back({1'b1, 8'hC0});
        expect_byte(8'hC0, 0, 1'b0);
        expect_byte(8'h41, 2, 1'b0);
        wait_drain("lockmax", 3000);
        wait_tx_done("lockmax");
        busy_len = 10;

        // Idle timeout: requester 3 sends a non-final byte then goes quiet
        rq[3].push_back({1'b0, 8'hD3});
        expect_byte(8'hD3, 3, 1'b0);
        wait_drain("idle", 200);
        wait_tx_done("idle");
        repeat (200) step();
        chk("idle_grant_held", grant, 4'b1000);
        chk("idle_locked_held", locked, 1);
        repeat (80) step();
        chk("idle_grant_released", grant, 0);
        chk("idle_locked_released", locked, 0);

        // ACK timeout: transmitter never answers
        ack_en = 1'b0;
        rq[1].push_back({1'b1, 8'hE1});
        expect_byte(8'hE1, 1, 1'b0);
        wait_drain("ack", 200);
        n = 0;
        while (cyc < last_start_cyc + ACK_TIMEOUT - 2 && n < 100) begin step(); n++; end
        chk("ack_err_early", err_timeout, 0);
        while (cyc < last_start_cyc + ACK_TIMEOUT + 1 && n < 100) begin step(); n++; end
        chk("ack_err_set", err_timeout, 1);
        chk("ack_grant_cleared", grant, 0);
        step();
        chk("ack_err_sticky", err_timeout, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("ack_err_cleared", err_timeout, 0);
        ack_en = 1'b1;
        rq[1].push_back({1'b1, 8'hB1});
        rq[2].push_back({1'b1, 8'hB2});
        expect_byte(8'hB2, 2, 1'b0);
        expect_byte(8'hB1, 1, 1'b0);
        wait_drain("after_ack", 500);
        wait_tx_done("after_ack");

        // Reset while the transmitter is mid-frame
        busy_len = 30;
        rq[3].push_back({1'b1, 8'hA5});
        expect_byte(8'hA5, 3, 1'b0);
        wait_drain("midreset", 200);
        n = 0;
        while (!tx_busy && n < 50) begin step(); n++; end
        chk("midreset_busy", tx_busy, 1);
        repeat (3) step();
        wb_rst_i = 1'b1;
        step();
        chk_reset_values("midreset");
        wb_rst_i = 1'b0;
        busy_len = 10;
        rq[0].push_back({1'b1, 8'h5A});
        expect_byte(8'h5A, 0, 1'b0);
        n = 0;
        while (tx_busy && n < 60) begin
            chk("midreset_no_start", tx_start, 0);
            chk("midreset_no_ready", req_ready, 0);
            step();
            n++;
        end
        chk("midreset_busy_fell", tx_busy, 0);
        wait_drain("midreset_after", 200);
        wait_tx_done("midreset_after");
        chk("scoreboard_empty", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
